// File: rtl/mac_pkg.sv
// Shared definitions for the MAC controller family: controller state encoding
// and the accumulator width derivation.
`timescale 1ns/1ps
package mac_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } mac_state_e;

    // A full 2N-bit product summed up to 2^len_w - 1 times needs len_w guard bits.
    function automatic int acc_width(input int n, input int len_w);
        return 2 * n + len_w;
    endfunction

endpackage

// File: rtl/mac_acc_slice.sv
// Signed N x N multiplier feeding an ACC_W-bit accumulator with synchronous
// clear (priority over enable) and asynchronous active-low reset.
`timescale 1ns/1ps
module mac_acc_slice #(
    parameter int N     = 18,
    parameter int ACC_W = 44
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     b,
    output logic [ACC_W-1:0] acc
);

    logic signed [2*N-1:0] a_ext;
    logic signed [2*N-1:0] b_ext;
    logic signed [2*N-1:0] prod;
    logic [ACC_W-1:0]      prod_ext;
    logic [ACC_W-1:0]      acc_d;
    logic [ACC_W-1:0]      acc_q;

    // Widen operands first so the low 2N bits of the product are exact.
    assign a_ext    = {{N{a[N-1]}}, a};
    assign b_ext    = {{N{b[N-1]}}, b};
    assign prod     = a_ext * b_ext;
    assign prod_ext = {{(ACC_W - 2*N){prod[2*N-1]}}, prod};

    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_q + prod_ext;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/mac_dot_ctrl.sv
// Dot-product sequencer: walks two operand memories in lock-step, accumulates
// the returned pairs in a MAC slice and presents the sum on a valid/ready port.
`timescale 1ns/1ps
module mac_dot_ctrl
    import mac_pkg::*;
#(
    parameter int N      = 18,
    parameter int LEN_W  = 8,
    parameter int ADDR_W = 10
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic [LEN_W-1:0]                   len,
    input  logic [ADDR_W-1:0]                  base_w,
    input  logic [ADDR_W-1:0]                  base_x,
    input  logic                               abort,
    output logic                               busy,
    output logic                               rd_en,
    output logic [ADDR_W-1:0]                  w_addr,
    output logic [ADDR_W-1:0]                  x_addr,
    input  logic [N-1:0]                       w_data,
    input  logic [N-1:0]                       x_data,
    output logic                               res_valid,
    input  logic                               res_ready,
    output logic [acc_width(N, LEN_W)-1:0]     result
);

    localparam int ACC_W = acc_width(N, LEN_W);

    mac_state_e       state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             rd_en_q, rd_en_d;
    logic             vld_q, vld_d;
    logic             busy_q, busy_d;
    logic             res_valid_q, res_valid_d;

    logic             addr_load;
    logic             addr_step;
    logic             kill;
    logic             acc_clr;
    logic             acc_en;
    logic [ACC_W-1:0] acc;

    logic [1:0][ADDR_W-1:0] base_lane;
    logic [1:0][ADDR_W-1:0] addr_lane;

    // Lane 0 walks the W memory, lane 1 the X memory.
    assign base_lane = {base_x, base_w};

    // ------------------------------------------------------------------
    // FSM: next state, counter and address-lane strobes
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        rd_en_d   = 1'b0;
        addr_load = 1'b0;
        addr_step = 1'b0;
        acc_clr   = 1'b0;
        kill      = abort && ((state_q == RUN) || (state_q == DRAIN));

        case (state_q)
            IDLE: begin
                if (start) begin
                    len_d     = len;
                    cnt_d     = '0;
                    acc_clr   = 1'b1;
                    addr_load = 1'b1;
                    if (len != '0) begin
                        state_d = RUN;
                        rd_en_d = 1'b1;
                        cnt_d   = LEN_W'(1);
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            RUN: begin
                // cnt_q counts reads issued including the one on the bus now.
                if (abort) begin
                    state_d = IDLE;
                end else if (cnt_q == len_q) begin
                    state_d = DRAIN;
                end else begin
                    rd_en_d   = 1'b1;
                    addr_step = 1'b1;
                    cnt_d     = cnt_q + LEN_W'(1);
                end
            end
            DRAIN: begin
                state_d = abort ? IDLE : DONE;
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // An abort discards both the pair arriving now and the one in flight.
        vld_d       = rd_en_q && !kill;
        acc_en      = vld_q && !kill;
        busy_d      = (state_d != IDLE);
        res_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            len_q       <= '0;
            cnt_q       <= '0;
            rd_en_q     <= 1'b0;
            vld_q       <= 1'b0;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            rd_en_q     <= rd_en_d;
            vld_q       <= vld_d;
            busy_q      <= busy_d;
            res_valid_q <= res_valid_d;
        end
    end

    // ------------------------------------------------------------------
    // Address lanes: load the base on accept, step while reading.
    // Addresses wrap naturally at 2^ADDR_W.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_addr
            logic [ADDR_W-1:0] addr_q;
            logic [ADDR_W-1:0] addr_d;

            always_comb begin
                addr_d = addr_q;
                if (addr_load) begin
                    addr_d = base_lane[gi];
                end else if (addr_step) begin
                    addr_d = addr_q + ADDR_W'(1);
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    addr_q <= '0;
                end else begin
                    addr_q <= addr_d;
                end
            end

            assign addr_lane[gi] = addr_q;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Multiply-accumulate slice
    // ------------------------------------------------------------------
    mac_acc_slice #(
        .N     (N),
        .ACC_W (ACC_W)
    ) u_acc (
        .clk (clk),
        .rst (rst),
        .clr (acc_clr),
        .en  (acc_en),
        .a   (w_data),
        .b   (x_data),
        .acc (acc)
    );

    assign busy      = busy_q;
    assign rd_en     = rd_en_q;
    assign w_addr    = addr_lane[0];
    assign x_addr    = addr_lane[1];
    assign res_valid = res_valid_q;
    assign result    = acc;

endmodule

// File: doc/mac_dot_ctrl.md
# mac_dot_ctrl

Sequencer that computes a signed dot product of two operand vectors held in on-chip memories. It issues read addresses, feeds returned operand pairs through a multiply-accumulate slice, and returns the final sum over a valid/ready result handshake. It sits between a host/command source and the weight/activation memories and owns the accumulator's lifetime (clear, accumulate, hold) per job.

## Interface

Parameters:
- N, 18, signed operand width.
- LEN_W, 8, vector-length field width; maximum job length 2^LEN_W − 1.
- ADDR_W, 10, memory address width.
- ACC_W, 2*N+LEN_W, accumulator and result width (derived; not overridden).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  job request; accepted only in IDLE.
- len  in  LEN_W  number of element pairs; sampled with start.
- base_w  in  ADDR_W  first W address; sampled with start.
- base_x  in  ADDR_W  first X address; sampled with start.
- abort  in  1  synchronous job cancel.
- busy  out  1  high in every state except IDLE.
- rd_en  out  1  memory read strobe.
- w_addr  out  ADDR_W  W read address.
- x_addr  out  ADDR_W  X read address.
- w_data  in  N  signed W word, valid exactly 1 cycle after rd_en.
- x_data  in  N  signed X word, valid exactly 1 cycle after rd_en.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- result  out  ACC_W  signed dot product.

## Operation

- States: IDLE, RUN, DRAIN, DONE.
- IDLE: start=1 → latch len, base_w, base_x; clear the accumulator to 0; clear the element counter. Go to RUN if len≠0, else go directly to DONE with result 0.
- RUN: rd_en=1 and w_addr=base_w+k, x_addr=base_x+k for k=0..len−1, one pair per cycle. After issuing k=len−1, go to DRAIN.
- Addresses wrap modulo 2^ADDR_W; no error is flagged.
- Data pipeline: a 1-bit valid register (rd_en delayed by 1 cycle) gates accumulation. acc <= acc + sext(w_data*x_data) on each valid cycle. The product is a full 2N-bit signed value, sign-extended to ACC_W. No overflow is possible within the maximum job length.
- DRAIN: one cycle that absorbs the last returned pair. Go to DONE.
- DONE: res_valid=1 and result=acc, both held stable until res_ready=1. On the handshake cycle go to IDLE.
- start is ignored while busy=1. start in the same cycle as a DONE handshake is ignored; a job can begin no earlier than the next IDLE cycle.
- abort=1 in RUN or DRAIN: go to IDLE next cycle; rd_en drops that next cycle; in-flight data is discarded; no result is produced.
- abort in DONE or IDLE has no effect.
- abort and start in the same IDLE cycle: start wins.
- Reset (rst=0, any time, including mid-job): state=IDLE, busy=0, rd_en=0, res_valid=0, result=0, w_addr=0, x_addr=0, accumulator=0, valid pipe=0.

## Timing

- Cycle 0: start accepted in IDLE.
- Cycles 1..len: RUN, one read per cycle.
- Cycle len+1: DRAIN; last accumulate at its end.
- Cycle len+2: res_valid rises.
- Job latency start→res_valid is len+2 cycles; len=0 gives 1 cycle.
- Throughput: one element pair per cycle. Back-to-back jobs have a minimum 1 IDLE cycle between the result handshake and the next start.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure

- Shared package mac_pkg holds the state enum (IDLE/RUN/DRAIN/DONE) and the ACC_W derivation helper, for reuse by sibling MAC controllers.
- One sub-module: mac_acc_slice, a signed multiply plus accumulator with synchronous clear and enable inputs and asynchronous active-low reset.
- The controller holds the FSM, counter, address generation and valid pipe.

## Test plan

- Basic dot product: len=3, base_w=0, base_x=16, W={1,−2,3}, X={4,5,−6} → result=−24; res_valid at cycle 5; exactly 3 rd_en cycles.
- Extremes: len=255, all W=X=−131072 (most negative 18-bit) → result=255·2^34 with no overflow. Back-to-back second job len=1, W=2, X=3 → result=6, confirming the accumulator was cleared.
- Zero length and wrap: len=0 → res_valid 1 cycle after start, result=0, rd_en never asserted. Then len=4, base_w=1022 → w_addr sequence 1022, 1023, 0, 1.
- Backpressure and ignored start: hold res_ready=0 for 10 cycles → result and res_valid stay stable. Pulse start during that hold → ignored, busy stays 1.
- Abort: abort at the 2nd RUN cycle of a len=8 job → IDLE next cycle, no res_valid. A following len=2 job returns the correct fresh sum.
- Reset mid-job: rst=0 during RUN → all outputs 0 immediately (asynchronous). After release, start with len=1 behaves as from power-up.
